// File: rtl/lc2k_control.sv
// Multicycle control FSM for the LC-2K datapath: sequences fetch/decode/
// execute/memory/writeback, drives mux selects and write enables, runs the
// req/ready handshake with unified memory and counts fetched instructions.
module lc2k_control #(
  parameter int unsigned COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        instr,
  input  logic               alu_zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_we,
  output logic               mem_addr_sel,
  output logic               ir_write,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               alu_srcb,
  output logic [1:0]         alu_op,
  output logic               reg_write,
  output logic               reg_dst,
  output logic [1:0]         wb_sel,
  output logic               halted,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALTED = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_NAND = 3'b001,
    OP_LW   = 3'b010,
    OP_SW   = 3'b011,
    OP_BEQ  = 3'b100,
    OP_JALR = 3'b101,
    OP_HALT = 3'b110,
    OP_NOOP = 3'b111
  } opcode_e;

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  opcode_e              opcode;

  assign opcode      = opcode_e'(instr[24:22]);
  assign state       = state_q;
  assign instr_count = count_q;

  // State and retired-instruction counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state and Moore-style outputs; handshake/zero inputs gate enables.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'd0;
    alu_srcb     = 1'b0;
    alu_op       = 2'd0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    wb_sel       = 2'd0;
    halted       = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          count_d  = count_q + 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        if (opcode == OP_HALT)      state_d = S_HALTED;
        else if (opcode == OP_NOOP) state_d = S_FETCH;
        else                        state_d = S_EXEC;
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_ADD:  state_d = S_WB;
          OP_NAND: begin
            alu_op  = 2'd1;
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_srcb = 1'b1;
            state_d  = S_MEM;
          end
          OP_BEQ: begin
            alu_op   = 2'd2;
            pc_write = alu_zero;
            pc_src   = 2'd1;
          end
          OP_JALR: begin
            // PC loads regA as read this cycle, so regA==regB still jumps
            // to the old regA value while the link is written.
            reg_write = 1'b1;
            reg_dst   = 1'b1;
            wb_sel    = 2'd2;
            pc_write  = 1'b1;
            pc_src    = 2'd2;
          end
          default: state_d = S_FETCH;
        endcase
      end

      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_SW);
        if (mem_ready) state_d = (opcode == OP_LW) ? S_WB : S_FETCH;
      end

      S_WB: begin
        reg_write = 1'b1;
        if (opcode == OP_LW) begin
          reg_dst = 1'b1;
          wb_sel  = 2'd1;
        end
        state_d = S_FETCH;
      end

      S_HALTED: halted = 1'b1;

      default: state_d = S_FETCH;
    endcase
  end

endmodule
